rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource, such as a priority-encoder datapath or bus port, between N requesters.
- Grants one requester at a time with a registered one-hot grant and its binary index.
- Holds the grant until the owner drops its request or a hold-timeout expires.
- Sits between requester FSMs and the shared resource; the grant drives the resource's input mux and valid qualifier.

---
 rtl/rr_arbiter.sv | 107 ++++++++++
 tb/tb_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a hold-timeout.
// The owner keeps the grant until it drops its request or MAX_HOLD cycles have elapsed.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_val_o,
  output logic             timeout_o
);

  localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             val_q, val_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    hold_q, hold_d;

  // Rotate so that bit 0 of req_rot corresponds to the requester at ptr.
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] sel_idx;
  int               sel_off;
  int               sel_sum;

  assign req_rot = N'({req_i, req_i} >> ptr_q);

  always_comb begin
    sel_off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_off = i;
    end
    sel_sum = int'(ptr_q) + sel_off;
    if (sel_sum >= N) sel_sum = sel_sum - N;
    sel_idx = IDX_W'(sel_sum);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    val_d     = val_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = N'(1) << sel_idx;
          idx_d   = sel_idx;
          val_d   = 1'b1;
          hold_d  = CW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Both release kinds hand priority to the requester after the owner.
        if (!req_i[idx_q] || (MAX_HOLD != 0 && hold_q == CW'(MAX_HOLD))) begin
          gnt_d     = '0;
          idx_d     = '0;
          val_d     = 1'b0;
          ptr_d     = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
          timeout_d = req_i[idx_q];
          state_d   = IDLE;
        end else if (hold_q != '1) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      val_q     <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_val_o = val_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against an ownership-level reference model.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       srst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_val;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i     (clk),
    .srst_n_i  (srst_n),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_val_o (gnt_val),
    .timeout_o (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: who owns the resource, how long, and where the search starts next.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  always @(posedge clk) begin
    if (!srst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_to    = 1'b0;
    end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
      m_to  = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e_idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    checks++;
    if ({gnt, gnt_idx, gnt_val, timeout} !== {e_gnt, e_idx, (m_owner >= 0), m_to}) begin
      errors++;
      $display("[TB] FAIL model t=%0t: got gnt=%b idx=%0d val=%b to=%b, expected gnt=%b idx=%0d val=%b to=%b",
               $time, gnt, gnt_idx, gnt_val, timeout, e_gnt, e_idx, (m_owner >= 0), m_to);
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic rn);
    req    = r;
    srst_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] ei,
                             input logic ev, input logic et);
    checks++;
    if ({gnt, gnt_idx, gnt_val, timeout} !== {eg, ei, ev, et}) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d val=%b to=%b, expected gnt=%b idx=%0d val=%b to=%b",
               name, gnt, gnt_idx, gnt_val, timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    int owners[5];
    logic [3:0] r;
    owners = '{2, 3, 0, 1, 2};
    req    = 4'b1111;
    srst_n = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0);
      checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    applyStimulus(4'b1111, 1'b1);
    checkOutput("first_after_reset", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("release0", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0010, 1'b1);
      checkOutput("single", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr is 2 here, so the rotation visits 2,3,0,1,2.
    foreach (owners[k]) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rotate_grant", 4'b0001 << owners[k], 2'(owners[k]), 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rotate_hold", 4'b0001 << owners[k], 2'(owners[k]), 1'b1, 1'b0);
      r = 4'b1111 & ~(4'b0001 << owners[k]);
      applyStimulus(r, 1'b1);
      checkOutput("rotate_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1001, 1'b1);
      checkOutput("wrap_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("wrap_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("wrap_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < MAX_HOLD; i++) begin
      applyStimulus(4'b0100, 1'b1);
      checkOutput("timeout_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(4'b0100, 1'b1);
    checkOutput("timeout_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("timeout_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("timeout_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus((i == 0) ? 4'b0010 : 4'b0011, 1'b1);
      checkOutput("midgrant_owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0011, 1'b0);
    checkOutput("midgrant_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("after_reset_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1);

    applyStimulus(4'b1000, 1'b1);
    checkOutput("glitch_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("glitch_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) r = 4'b0001 << $urandom_range(0, 3);
      applyStimulus(r, ($urandom_range(0, 149) != 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
